// File: rtl/or1200_mem_arbiter.sv
// rtl/or1200_mem_arbiter.sv - single-port RAM arbiter between OR1200 I-fetch and data ports
//
// Purpose:
//    Shares one single-port synchronous RAM (1-cycle read latency) between the
//    CPU instruction-fetch port (read-only) and the data port (read/write).
//    The data port has fixed priority.  A saturating starvation counter forces
//    an instruction grant once the I-port has been denied STARVE_LIMIT
//    consecutive cycles.  Read data is steered back to the port that owned
//    the read one cycle after its grant.
//
// Ports:
//    clk, rst               clock, synchronous active-high reset
//    i_req/i_addr           instruction read request and byte address
//    i_gnt                  instruction request accepted this cycle
//    i_rvalid/i_rdata       instruction read return (cycle after i_gnt)
//    d_req/d_we/d_addr/
//    d_wdata                data request, direction, address, write data
//    d_gnt                  data request accepted this cycle
//    d_rvalid/d_rdata       data read return (cycle after a read d_gnt)
//    mem_en/mem_we/
//    mem_addr/mem_wdata     RAM strobe, write enable, address, write data
//    mem_rdata              RAM read data, valid the cycle after a read strobe

module or1200_mem_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_gnt,
   output logic          i_rvalid,
   output logic [DW-1:0] i_rdata,

   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,

   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   logic [3:0] starve_cnt_q, starve_cnt_d;
   logic [1:0] rd_owner_q, rd_owner_d;   // {data read, instruction read} granted last cycle

   logic force_i;
   logic sel_i;
   logic sel_d;

   assign force_i = (starve_cnt_q >= 4'(STARVE_LIMIT));

   // Grants are suppressed while in reset so the RAM sees no strobe.
   assign sel_i = !rst && i_req && (!d_req || force_i);
   assign sel_d = !rst && d_req && !sel_i;

   assign i_gnt = sel_i;
   assign d_gnt = sel_d;

   always_comb begin
      mem_en    = sel_i | sel_d;
      mem_we    = sel_d & d_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (sel_i) begin
         mem_addr = i_addr;
      end else if (sel_d) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end
   end

   // Counts consecutive cycles the I-port requests without being granted;
   // any grant or withdrawal of the request restarts the count.
   always_comb begin
      starve_cnt_d = 4'd0;
      if (i_req && !sel_i) begin
         starve_cnt_d = (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;
      end
   end

   assign rd_owner_d = {sel_d & !d_we, sel_i};

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= 4'd0;
         rd_owner_q   <= 2'b00;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         rd_owner_q   <= rd_owner_d;
      end
   end

   // A read granted just before reset is dropped: the return is masked while
   // reset is high, and the owner pipeline is cleared at the same edge.
   assign i_rvalid = rd_owner_q[0] & !rst;
   assign d_rvalid = rd_owner_q[1] & !rst;
   assign i_rdata  = i_rvalid ? mem_rdata : '0;
   assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule
